// File: rtl/glip_uart_pkg.sv
// Shared constants, state encodings and credit message type for the GLIP UART host link.
// No logic; imported by the host control top and its receive decoder.
package glip_uart_pkg;

  localparam logic [7:0] ESCAPE        = 8'hFE;
  localparam logic [7:0] CODE_LRST_SET = 8'h02;
  localparam logic [7:0] CODE_LRST_CLR = 8'h03;

  localparam int TX_CREDIT_W  = 16;
  localparam int DEV_CREDIT_W = 15;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_ESC,
    TX_CODE,
    TX_CRED_LO,
    TX_DATA
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_NORM,
    RX_ESC,
    RX_CRED_LO
  } rx_state_t;

  typedef struct packed {
    logic                    vld;
    logic [DEV_CREDIT_W-1:0] value;
  } credit_msg_t;

endpackage

// File: rtl/glip_uart_host_control_if.sv
// Host byte streams, UART byte transmitter/receiver handshakes and error flag of the host link.
// master is the protocol endpoint; slave is the surrounding host logic and UART pair.
interface glip_uart_host_control_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_free;
  logic       logic_rst_req;
  logic [7:0] uart_tx_data;
  logic       uart_tx_enable;
  logic       uart_tx_done;
  logic [7:0] uart_rx_data;
  logic       uart_rx_enable;
  logic       error;

  modport master (
    input  tx_data, tx_valid, rx_free, logic_rst_req, uart_tx_done, uart_rx_data, uart_rx_enable,
    output tx_ready, rx_data, rx_valid, uart_tx_data, uart_tx_enable, error
  );

  modport slave (
    output tx_data, tx_valid, rx_free, logic_rst_req, uart_tx_done, uart_rx_data, uart_rx_enable,
    input  tx_ready, rx_data, rx_valid, uart_tx_data, uart_tx_enable, error
  );
endinterface

// File: rtl/glip_uart_host_rx_decode.sv
// Unescapes device bytes; data strobe registered 1 cycle after uart_rx_enable, credit pulse same cycle.
// No backpressure: bytes arriving without device credit are dropped and flagged.
module glip_uart_host_rx_decode
  import glip_uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_enable,
  input  logic        dev_credit_zero,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        data_take,
  output credit_msg_t credit,
  output logic        err
);

  rx_state_t  state, state_nxt;
  logic [6:0] cred_hi, cred_hi_nxt;
  logic       is_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RX_NORM;
      cred_hi <= '0;
    end else begin
      state   <= state_nxt;
      cred_hi <= cred_hi_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cred_hi_nxt = cred_hi;
    is_data     = 1'b0;
    credit      = '0;
    err         = 1'b0;
    data_take   = 1'b0;
    if (uart_rx_enable) begin
      case (state)
        RX_NORM: begin
          if (uart_rx_data == ESCAPE) state_nxt = RX_ESC;
          else                        is_data   = 1'b1;
        end
        RX_ESC: begin
          state_nxt = RX_NORM;
          if (uart_rx_data == ESCAPE) begin
            is_data = 1'b1;
          end else if (uart_rx_data[7]) begin
            cred_hi_nxt = uart_rx_data[6:0];
            state_nxt   = RX_CRED_LO;
          end else begin
            // includes the logic-reset codes, which only the host may send
            err = 1'b1;
          end
        end
        RX_CRED_LO: begin
          credit.vld   = 1'b1;
          credit.value = {cred_hi, uart_rx_data};
          state_nxt    = RX_NORM;
        end
        default: state_nxt = RX_NORM;
      endcase
    end
    data_take = is_data & ~dev_credit_zero;
    err       = err | (is_data & dev_credit_zero);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_valid <= data_take;
      if (data_take) rx_data <= uart_rx_data;
    end
  end

endmodule

// File: rtl/glip_uart_host_control.sv
// GLIP UART host endpoint: escapes/credits outgoing bytes, decodes device traffic; uart_tx registered (+1 cycle).
// tx_ready only in IDLE with tx credit and no pending control/credit message; no rx backpressure.
module glip_uart_host_control
  import glip_uart_pkg::*;
#(
  parameter int INGRESS_CREDIT   = 4090,
  parameter int CREDIT_THRESHOLD = 64
) (
  input logic                      clk,
  input logic                      rst,
  glip_uart_host_control_if.master bus
);

  localparam logic [DEV_CREDIT_W-1:0] PENDING_INIT = DEV_CREDIT_W'(INGRESS_CREDIT);
  localparam logic [DEV_CREDIT_W-1:0] THRESH       = DEV_CREDIT_W'(CREDIT_THRESHOLD);

  tx_state_t               state, state_nxt;
  logic [TX_CREDIT_W-1:0]  tx_credit;
  logic [DEV_CREDIT_W-1:0] dev_credit;
  logic [DEV_CREDIT_W-1:0] pending;
  logic [DEV_CREDIT_W-1:0] grant, grant_nxt;
  logic [7:0]              second, second_nxt;
  logic                    is_cred, is_cred_nxt;
  logic                    lrst_sent, lrst_sent_nxt;
  logic                    load;
  logic [7:0]              load_byte;
  logic                    accept;
  logic                    grant_done;
  logic                    tx_ready_c;
  logic [7:0]              uart_tx_data_q;
  logic                    uart_tx_enable_q;
  logic                    error_q;
  logic [TX_CREDIT_W:0]    tx_credit_sum;
  logic                    tx_credit_ovf;

  logic [7:0]  dec_rx_data;
  logic        dec_rx_valid;
  logic        data_take;
  credit_msg_t dec_credit;
  logic        dec_err;

  glip_uart_host_rx_decode u_rx_decode (
    .clk             (clk),
    .rst             (rst),
    .uart_rx_data    (bus.uart_rx_data),
    .uart_rx_enable  (bus.uart_rx_enable),
    .dev_credit_zero (dev_credit == '0),
    .rx_data         (dec_rx_data),
    .rx_valid        (dec_rx_valid),
    .data_take       (data_take),
    .credit          (dec_credit),
    .err             (dec_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= TX_IDLE;
      grant     <= '0;
      second    <= '0;
      is_cred   <= 1'b0;
      lrst_sent <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      second    <= second_nxt;
      is_cred   <= is_cred_nxt;
      lrst_sent <= lrst_sent_nxt;
    end
  end

  // Each state names the byte on the wire; CODE/CRED_LO load their byte once enable has dropped.
  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    second_nxt    = second;
    is_cred_nxt   = is_cred;
    lrst_sent_nxt = lrst_sent;
    load          = 1'b0;
    load_byte     = ESCAPE;
    accept        = 1'b0;
    grant_done    = 1'b0;
    tx_ready_c    = 1'b0;
    case (state)
      TX_IDLE: begin
        if (bus.logic_rst_req != lrst_sent) begin
          lrst_sent_nxt = bus.logic_rst_req;
          second_nxt    = bus.logic_rst_req ? CODE_LRST_SET : CODE_LRST_CLR;
          is_cred_nxt   = 1'b0;
          load          = 1'b1;
          state_nxt     = TX_ESC;
        end else if (pending >= THRESH) begin
          grant_nxt   = pending;
          second_nxt  = {1'b1, pending[14:8]};
          is_cred_nxt = 1'b1;
          load        = 1'b1;
          state_nxt   = TX_ESC;
        end else if (tx_credit != '0 && bus.tx_valid) begin
          tx_ready_c  = 1'b1;
          accept      = 1'b1;
          is_cred_nxt = 1'b0;
          load        = 1'b1;
          if (bus.tx_data == ESCAPE) begin
            second_nxt = ESCAPE;
            state_nxt  = TX_ESC;
          end else begin
            load_byte = bus.tx_data;
            state_nxt = TX_DATA;
          end
        end
      end
      TX_ESC: begin
        if (bus.uart_tx_done) state_nxt = TX_CODE;
      end
      TX_CODE: begin
        if (!uart_tx_enable_q) begin
          load      = 1'b1;
          load_byte = second;
        end else if (bus.uart_tx_done) begin
          state_nxt = is_cred ? TX_CRED_LO : TX_IDLE;
        end
      end
      TX_CRED_LO: begin
        if (!uart_tx_enable_q) begin
          load      = 1'b1;
          load_byte = grant[7:0];
        end else if (bus.uart_tx_done) begin
          grant_done = 1'b1;
          state_nxt  = TX_IDLE;
        end
      end
      TX_DATA: begin
        if (bus.uart_tx_done) state_nxt = TX_IDLE;
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uart_tx_enable_q <= 1'b0;
      uart_tx_data_q   <= '0;
    end else if (load) begin
      uart_tx_enable_q <= 1'b1;
      uart_tx_data_q   <= load_byte;
    end else if (bus.uart_tx_done) begin
      uart_tx_enable_q <= 1'b0;
    end
  end

  // Accept can only happen with tx_credit > 0, so the sum never underflows.
  always_comb begin
    tx_credit_sum = {1'b0, tx_credit}
                  + (dec_credit.vld ? (TX_CREDIT_W+1)'(dec_credit.value) : '0)
                  - (TX_CREDIT_W+1)'(accept);
    tx_credit_ovf = tx_credit_sum[TX_CREDIT_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_credit  <= '0;
      dev_credit <= '0;
      pending    <= PENDING_INIT;
      error_q    <= 1'b0;
    end else begin
      tx_credit  <= tx_credit_ovf ? '1 : tx_credit_sum[TX_CREDIT_W-1:0];
      dev_credit <= dev_credit + (grant_done ? grant : '0) - DEV_CREDIT_W'(data_take);
      pending    <= pending - (grant_done ? grant : '0) + DEV_CREDIT_W'(bus.rx_free);
      error_q    <= error_q | dec_err | tx_credit_ovf;
    end
  end

  assign bus.tx_ready       = tx_ready_c;
  assign bus.rx_data        = dec_rx_data;
  assign bus.rx_valid       = dec_rx_valid;
  assign bus.uart_tx_data   = uart_tx_data_q;
  assign bus.uart_tx_enable = uart_tx_enable_q;
  assign bus.error          = error_q;

endmodule

// File: tb/tb_glip_uart_host_control.sv
// Directed bench for glip_uart_host_control with a UART transmitter responder and rx strobe capture.
module tb_glip_uart_host_control;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  glip_uart_host_control_if bus();

  glip_uart_host_control #(.INGRESS_CREDIT(4090), .CREDIT_THRESHOLD(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // UART transmitter model: byte leaves the wire after 3 cycles of enable.
  initial begin
    int cnt;
    cnt = 0;
    bus.uart_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cnt = 0;
        bus.uart_tx_done = 1'b0;
      end else if (bus.uart_tx_done) begin
        bus.uart_tx_done = 1'b0;
      end else if (bus.uart_tx_enable) begin
        cnt++;
        if (cnt == 3) begin
          txq.push_back(bus.uart_tx_data);
          bus.uart_tx_done = 1'b1;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  always @(negedge clk) if (bus.rx_valid) rxq.push_back(bus.rx_data);

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(negedge clk);
    bus.uart_rx_data   = b;
    bus.uart_rx_enable = 1'b1;
    @(negedge clk);
    bus.uart_rx_enable = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int budget, output bit ok);
    for (int i = 0; i < budget && txq.size() < n; i++) @(negedge clk);
    ok = (txq.size() >= n);
  endtask

  task automatic send_tx(input logic [7:0] b, input int budget, output bit ok);
    ok = 1'b0;
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    #1;
    for (int i = 0; i < budget; i++) begin
      if (bus.tx_ready) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
        break;
      end
      @(negedge clk);
      #1;
    end
    bus.tx_valid = 1'b0;
  endtask

  task automatic pulse_free();
    @(negedge clk);
    bus.rx_free = 1'b1;
    @(negedge clk);
    bus.rx_free = 1'b0;
  endtask

  task automatic hold_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    txq.delete();
    rxq.delete();
  endtask

  initial begin
    bit ok;
    bit seen;
    bus.tx_data        = '0;
    bus.tx_valid       = 1'b0;
    bus.rx_free        = 1'b0;
    bus.logic_rst_req  = 1'b0;
    bus.uart_rx_data   = '0;
    bus.uart_rx_enable = 1'b0;

    // reset state
    hold_reset();
    chk("rst_tx_enable", bus.uart_tx_enable, 0);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_tx_ready", bus.tx_ready, 0);
    chk("rst_pending", dut.pending, 4090);
    rst = 1'b0;

    // initial grant of the whole ingress buffer
    wait_tx(3, 100, ok);
    chk("grant_timeout", ok, 1);
    chk("grant_b0", txq[0], 8'hFE);
    chk("grant_b1", txq[1], 8'h8F);
    chk("grant_b2", txq[2], 8'hFA);
    cyc(5);
    chk("grant_dev_credit", dut.dev_credit, 4090);
    chk("grant_pending", dut.pending, 0);

    // no tx credit yet: byte must be held off
    bus.tx_data  = 8'h11;
    bus.tx_valid = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.tx_ready) seen = 1'b1;
    end
    bus.tx_valid = 1'b0;
    chk("nocred_ready", seen, 0);
    chk("nocred_wire", txq.size(), 3);

    // device grants 3 bytes; fourth host byte withheld
    rx_byte(8'hFE); rx_byte(8'h80); rx_byte(8'h03);
    cyc(3);
    chk("cred3_tx_credit", dut.tx_credit, 3);
    txq.delete();
    send_tx(8'h11, 60, ok); chk("tx11_accept", ok, 1);
    send_tx(8'hFE, 60, ok); chk("txFE_accept", ok, 1);
    send_tx(8'h22, 60, ok); chk("tx22_accept", ok, 1);
    send_tx(8'h33, 40, ok); chk("tx33_withheld", ok, 0);
    cyc(10);
    chk("tx_wire_count", txq.size(), 4);
    chk("tx_wire0", txq[0], 8'h11);
    chk("tx_wire1", txq[1], 8'hFE);
    chk("tx_wire2", txq[2], 8'hFE);
    chk("tx_wire3", txq[3], 8'h22);
    chk("tx_credit_empty", dut.tx_credit, 0);

    // device data with a literal escape
    rxq.delete();
    rx_byte(8'h41); rx_byte(8'hFE); rx_byte(8'hFE);
    cyc(3);
    chk("rx_count", rxq.size(), 2);
    chk("rx_b0", rxq[0], 8'h41);
    chk("rx_b1", rxq[1], 8'hFE);
    chk("rx_dev_credit", dut.dev_credit, 4088);
    chk("rx_error", bus.error, 0);

    // logic reset request outranks queued data
    rx_byte(8'hFE); rx_byte(8'h80); rx_byte(8'h02);
    cyc(3);
    txq.delete();
    bus.logic_rst_req = 1'b1;
    send_tx(8'h5A, 80, ok);
    chk("lrst_data_accept", ok, 1);
    wait_tx(3, 60, ok);
    cyc(8);
    chk("lrst_set_count", txq.size(), 3);
    chk("lrst_set_b0", txq[0], 8'hFE);
    chk("lrst_set_b1", txq[1], 8'h02);
    chk("lrst_set_b2", txq[2], 8'h5A);
    txq.delete();
    bus.logic_rst_req = 1'b0;
    wait_tx(2, 60, ok);
    cyc(8);
    chk("lrst_clr_count", txq.size(), 2);
    chk("lrst_clr_b0", txq[0], 8'hFE);
    chk("lrst_clr_b1", txq[1], 8'h03);

    // tx credit reaches the top exactly, then overflows and saturates
    rx_byte(8'hFE); rx_byte(8'hFF); rx_byte(8'hFF);
    rx_byte(8'hFE); rx_byte(8'hFF); rx_byte(8'hFF);
    cyc(3);
    chk("sat_exact", dut.tx_credit, 16'hFFFF);
    chk("sat_exact_error", bus.error, 0);
    rx_byte(8'hFE); rx_byte(8'h80); rx_byte(8'h01);
    cyc(3);
    chk("sat_ovf", dut.tx_credit, 16'hFFFF);
    chk("sat_ovf_error", bus.error, 1);

    // reset clears error; reset again in the middle of the first grant byte
    hold_reset();
    chk("rst2_error", bus.error, 0);
    chk("rst2_dev_credit", dut.dev_credit, 0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = bus.uart_tx_enable;
    end
    chk("midrst_started", seen, 1);
    rst = 1'b1;
    #1;
    chk("midrst_enable", bus.uart_tx_enable, 0);
    cyc(2);
    txq.delete();
    rst = 1'b0;
    wait_tx(3, 100, ok);
    cyc(5);
    chk("midrst_count", txq.size(), 3);
    chk("midrst_b0", txq[0], 8'hFE);
    chk("midrst_b1", txq[1], 8'h8F);
    chk("midrst_b2", txq[2], 8'hFA);

    // exhaust device credit, then one byte too many
    rxq.delete();
    for (int i = 0; i < 4090; i++) rx_byte(8'h30);
    cyc(3);
    chk("drain_rx_count", rxq.size(), 4090);
    chk("drain_dev_credit", dut.dev_credit, 0);
    chk("drain_error", bus.error, 0);
    rx_byte(8'h55);
    cyc(3);
    chk("overrun_rx_count", rxq.size(), 4090);
    chk("overrun_error", bus.error, 1);
    cyc(10);
    chk("overrun_error_sticky", bus.error, 1);

    // freed space reaches the threshold only on the 64th pop
    txq.delete();
    repeat (63) pulse_free();
    cyc(10);
    chk("free63_wire", txq.size(), 0);
    chk("free63_pending", dut.pending, 63);
    pulse_free();
    wait_tx(2, 60, ok);
    cyc(2);
    pulse_free();
    wait_tx(3, 60, ok);
    cyc(5);
    chk("free64_count", txq.size(), 3);
    chk("free64_b0", txq[0], 8'hFE);
    chk("free64_b1", txq[1], 8'h80);
    chk("free64_b2", txq[2], 8'h40);
    chk("free64_pending", dut.pending, 1);
    chk("free64_dev_credit", dut.dev_credit, 64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/glip_uart_host_control.md
# glip_uart_host_control

Host-side (DTE) endpoint of the GLIP UART link protocol: the counterpart of the device-side UART control logic. Sits between host-side byte streams and a UART byte transmitter/receiver pair, escaping outgoing data, issuing credit to the device, consuming device credit, and decoding incoming control sequences. Used in FPGA-to-FPGA links and as the protocol-accurate peer in device-side system benches.

## Interface
- INGRESS_CREDIT, 4090: host receive buffer depth in bytes; must be ≤ 16383.
- CREDIT_THRESHOLD, 64: minimum freed bytes before a credit message is sent; must be 1..INGRESS_CREDIT.

- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- tx_data  in  8  host byte to device
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  byte accepted this cycle (valid & ready)
- rx_data  out  8  device data byte, unescaped
- rx_valid  out  1  one-cycle strobe; external FIFO of INGRESS_CREDIT entries must accept it
- rx_free  in  1  one-cycle pulse per byte popped from that external FIFO
- logic_rst_req  in  1  level; requested state of device logic reset
- uart_tx_data  out  8  byte to UART transmitter
- uart_tx_enable  out  1  held high until uart_tx_done
- uart_tx_done  in  1  one-cycle pulse, byte on the wire
- uart_rx_data  in  8  byte from UART receiver
- uart_rx_enable  in  1  one-cycle strobe, uart_rx_data valid
- error  out  1  sticky protocol error

## Operation
- Wire format: escape byte E=0xFE. E,E = literal data 0xFE. E,B with B[7]=1, B≠0xFE = credit message; value = {B[6:0], next raw byte} (15 bit). E,0x02 / E,0x03 = device logic reset assert / deassert. Any other byte after E is an error.
- Counters: tx_credit (16 bit, bytes host may send), dev_credit (15 bit, bytes device may still send), pending (15 bit, freed host space not yet granted). Reset: tx_credit=0, dev_credit=0, pending=INGRESS_CREDIT.
- TX FSM states IDLE, ESC, CODE, CRED_LO, DATA. Priority in IDLE: (1) logic_rst_req differs from last-sent state → E, 0x02/0x03; (2) pending ≥ CREDIT_THRESHOLD → latch g=pending, send E, {1,g[14:8]}, g[7:0]; (3) tx_valid & tx_credit>0 → accept byte (tx_ready=1 for one cycle), send it, or E then 0xFE if byte is 0xFE.
- Credit message completion (done of low byte): pending -= g, dev_credit += g; concurrent rx_free adds 1 in the same cycle.
- Data byte: tx_credit decrements by 1 on acceptance; escape prefix consumes no credit.
- RX FSM states NORM, ESC, CRED_LO. Data byte in NORM (≠E) or literal E in ESC: if dev_credit=0 → error, byte dropped; else rx_valid strobe, dev_credit -= 1. Credit message adds value to tx_credit; sum > 0xFFFF → error, tx_credit saturates. Code 0x02/0x03 received from device → error (host-only codes).
- error is sticky until rst; protocol continues after error.

## Timing
- All outputs 0 after reset except pending-driven behaviour: first IDLE cycle after reset starts a credit message granting INGRESS_CREDIT (if ≥ threshold).
- uart_tx_enable and uart_tx_data registered; asserted the cycle after the FSM selects a byte; data stable while enable high; enable drops the cycle after uart_tx_done; next byte enable no earlier than the following cycle.
- rx_valid/rx_data registered: strobe one cycle after uart_rx_enable.
- tx_ready combinational only in IDLE, never during a message.
- Simultaneous rx_free and credit-grant completion: both applied. Simultaneous uart_rx credit and tx byte acceptance: tx_credit += value − 1.
- rst mid-message: byte aborted, FSMs to IDLE/NORM, counters to reset values.

## Structure
- Package glip_uart_pkg: ESCAPE=8'hFE, CODE_LRST_SET=8'h02, CODE_LRST_CLR=8'h03, TX and RX state enums, credit widths.
- Sub-module glip_uart_host_rx_decode: RX FSM, dev_credit check, outputs data strobe and credit-value pulse; TX FSM and counters stay in the top.

## Test plan
- Reset, INGRESS_CREDIT=4090 → first bytes sent FE, 0x8F, 0xFA; dev_credit=4090, pending=0.
- Device sends FE,0x80,0x03 then host tx bytes 0x11,0xFE,0x22,0x33 → wire 0x11,FE,FE,0x22,0x33 withheld until 4th: only 3 sent, tx_ready low after tx_credit=0.
- uart_rx bytes 0x41, FE, FE → rx_valid twice with 0x41, 0xFE; dev_credit −2.
- dev_credit=0, uart_rx byte 0x55 → no rx_valid, error=1 and stays 1.
- 64 rx_free pulses with threshold 64 → credit message FE, 0x80, 0x40 sent; rx_free during low byte counted in pending.
- logic_rst_req 0→1 while data queued → FE,0x02 sent before data; 1→0 → FE,0x03.
